// File: rtl/croc_pkg.sv
// Shared bus types for the croc SoC: subordinate-side OBI and regbus.
package croc_pkg;

  localparam int unsigned SbrObiAidWidth = 4;
  localparam logic [31:0] ObiRegErrRdata = 32'hBADC_AB1E;

  typedef struct packed {
    logic [31:0]               addr;
    logic                      we;
    logic [3:0]                be;
    logic [31:0]               wdata;
    logic [SbrObiAidWidth-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]               rdata;
    logic [SbrObiAidWidth-1:0] rid;
    logic                      err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/croc_obi_reg_responder.sv
// OBI subordinate that bridges one transaction at a time onto a regbus
// initiator, with a bounded wait that converts a hung peripheral into an error.
module croc_obi_reg_responder
  import croc_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [31:0] ErrRdata      = ObiRegErrRdata
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output reg_req_t     reg_req_o,
  input  reg_rsp_t     reg_rsp_i,
  output logic         busy_o
);

  // A zero timeout disables the check but still needs a 1-bit counter.
  localparam bit          TimeoutEn = (TimeoutCycles != 0);
  localparam int unsigned CntW      = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TimeoutCycles - 1) : '0;
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e                    state_q;
  reg_req_t                  reg_req_q;
  logic [SbrObiAidWidth-1:0] aid_q;
  logic [CntW-1:0]           cnt_q;
  logic                      rvalid_q;
  logic [31:0]               rdata_q;
  logic [SbrObiAidWidth-1:0] rid_q;
  logic                      err_q;
  logic                      busy_q;
  logic                      gnt;

  // Grant only while idle so at most one transaction is ever outstanding.
  assign gnt = obi_req_i.req && (state_q == IDLE);

  // Transaction FSM: latch request, run the regbus access, return one response beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      reg_req_q <= '0;
      aid_q     <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (obi_req_i.req) begin
            reg_req_q.addr  <= obi_req_i.a.addr;
            reg_req_q.write <= obi_req_i.a.we;
            reg_req_q.wdata <= obi_req_i.a.wdata;
            reg_req_q.wstrb <= obi_req_i.a.be;
            reg_req_q.valid <= 1'b1;
            aid_q           <= obi_req_i.a.aid;
            cnt_q           <= '0;
            busy_q          <= 1'b1;
            state_q         <= ACCESS;
          end
        end
        ACCESS: begin
          // Ready is checked first so it wins over a coincident timeout.
          if (reg_rsp_i.ready) begin
            rvalid_q        <= 1'b1;
            rdata_q         <= reg_req_q.write ? 32'h0 : reg_rsp_i.rdata;
            err_q           <= reg_rsp_i.error;
            rid_q           <= aid_q;
            reg_req_q.valid <= 1'b0;
            cnt_q           <= '0;
            state_q         <= RESP;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            rvalid_q        <= 1'b1;
            rdata_q         <= ErrRdata;
            err_q           <= 1'b1;
            rid_q           <= aid_q;
            reg_req_q.valid <= 1'b0;
            cnt_q           <= '0;
            state_q         <= RESP;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
          rid_q    <= '0;
          err_q    <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Pack the registered response fields onto the OBI response.
  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = gnt;
    obi_rsp_o.rvalid  = rvalid_q;
    obi_rsp_o.r.rdata = rdata_q;
    obi_rsp_o.r.rid   = rid_q;
    obi_rsp_o.r.err   = err_q;
  end

  assign reg_req_o = reg_req_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_croc_obi_reg_responder.sv
// Scoreboard bench for croc_obi_reg_responder with a short timeout.
module tb_croc_obi_reg_responder;
  import croc_pkg::*;

  localparam int unsigned T = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  reg_req_t     reg_req;
  reg_rsp_t     reg_rsp;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  croc_obi_reg_responder #(.TimeoutCycles(T)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .obi_req_i(obi_req),
    .obi_rsp_o(obi_rsp),
    .reg_req_o(reg_req),
    .reg_rsp_i(reg_rsp),
    .busy_o   (busy)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every rvalid beat.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (!rst_i) begin
      if (obi_rsp.rvalid) begin
        if (sb.size() == 0) begin
          chk("unexp_rvalid", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("rdata", 64'(obi_rsp.r.rdata), 64'(e.rdata));
          chk("rid", 64'(obi_rsp.r.rid), 64'(e.rid));
          chk("err", 64'(obi_rsp.r.err), 64'(e.err));
          chk("rv_cyc", 64'(cyc), 64'(e.cyc));
          $display("txn rid=%0d rdata=%h err=%0d cyc=%0d", obi_rsp.r.rid, obi_rsp.r.rdata,
                   obi_rsp.r.err, cyc);
        end
      end else begin
        chk("r_idle", 64'({obi_rsp.r.err, obi_rsp.r.rid, obi_rsp.r.rdata}), 64'(0));
      end
    end
  end

  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [3:0] aid, input int wait_n,
                         input logic [31:0] rd, input logic rerr, input bit tmo);
    exp_t e;
    int   g;
    int   n;
    obi_req.req     = 1'b1;
    obi_req.a.addr  = addr;
    obi_req.a.we    = we;
    obi_req.a.be    = be;
    obi_req.a.wdata = wdata;
    obi_req.a.aid   = aid;
    @(negedge clk_i);
    chk("gnt", 64'(obi_rsp.gnt), 64'(1));
    chk("busy_idle", 64'(busy), 64'(0));
    g       = cyc;
    e.rdata = tmo ? ObiRegErrRdata : (we ? 32'h0 : rd);
    e.rid   = aid;
    e.err   = tmo ? 1'b1 : rerr;
    e.cyc   = tmo ? g + 1 + int'(T) : g + 2 + wait_n;
    sb.push_back(e);
    tick();
    // Scramble the request so the regbus side must use the latched copy.
    obi_req.req     = 1'b0;
    obi_req.a.addr  = $urandom();
    obi_req.a.wdata = $urandom();
    obi_req.a.be    = ~be;
    obi_req.a.we    = ~we;
    n = tmo ? int'(T) : wait_n + 1;
    for (int i = 0; i < n; i++) begin
      if (!tmo && i == wait_n) begin
        reg_rsp.ready = 1'b1;
        reg_rsp.rdata = rd;
        reg_rsp.error = rerr;
      end
      @(negedge clk_i);
      chk("valid", 64'(reg_req.valid), 64'(1));
      chk("addr", 64'(reg_req.addr), 64'(addr));
      chk("write", 64'(reg_req.write), 64'(we));
      chk("wstrb", 64'(reg_req.wstrb), 64'(be));
      chk("wdata", 64'(reg_req.wdata), 64'(wdata));
      chk("busy", 64'(busy), 64'(1));
      tick();
      reg_rsp = '0;
    end
    if (tmo) begin
      reg_rsp.ready = 1'b1;
      reg_rsp.rdata = 32'h5555_5555;
    end
    @(negedge clk_i);
    chk("valid_resp", 64'(reg_req.valid), 64'(0));
    chk("busy_resp", 64'(busy), 64'(1));
    tick();
    reg_rsp = '0;
    @(negedge clk_i);
    chk("busy_done", 64'(busy), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   g1;
    obi_req = '0;
    reg_rsp = '0;
    rst_i   = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", 64'(obi_rsp.gnt), 64'(0));
    chk("rst_rvalid", 64'(obi_rsp.rvalid), 64'(0));
    chk("rst_r", 64'({obi_rsp.r.err, obi_rsp.r.rid, obi_rsp.r.rdata}), 64'(0));
    chk("rst_valid", 64'(reg_req.valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    tick();
    rst_i = 1'b0;

    // Directed cases: read, write with waits, regbus error, ready on last cycle, timeout.
    run_txn(32'h0300_2004, 1'b0, 4'hF, 32'h0, 4'd3, 0, 32'hA5A5_0001, 1'b0, 1'b0);
    run_txn(32'h0300_2008, 1'b1, 4'b0011, 32'h1234_5678, 4'd5, 4, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_txn(32'h0300_200C, 1'b0, 4'hF, 32'h0, 4'd7, 1, 32'h0BAD_0000, 1'b1, 1'b0);
    run_txn(32'h0300_2010, 1'b0, 4'hF, 32'h0, 4'd9, int'(T) - 1, 32'h1111_2222, 1'b0, 1'b0);
    run_txn(32'h0300_2014, 1'b0, 4'hF, 32'h0, 4'd2, 0, 32'h0, 1'b0, 1'b1);

    // Back-to-back with req held high: second grant only after the response.
    obi_req.req     = 1'b1;
    obi_req.a.addr  = 32'h0300_3000;
    obi_req.a.we    = 1'b0;
    obi_req.a.be    = 4'hF;
    obi_req.a.wdata = 32'h0;
    obi_req.a.aid   = 4'd1;
    @(negedge clk_i);
    chk("b2b_gnt0", 64'(obi_rsp.gnt), 64'(1));
    g1      = cyc;
    e.rdata = 32'hCAFE_0001;
    e.rid   = 4'd1;
    e.err   = 1'b0;
    e.cyc   = g1 + 2;
    sb.push_back(e);
    tick();
    obi_req.a.addr  = 32'h0300_3004;
    obi_req.a.we    = 1'b1;
    obi_req.a.be    = 4'hC;
    obi_req.a.wdata = 32'hDEAD_BEEF;
    obi_req.a.aid   = 4'd2;
    reg_rsp.ready   = 1'b1;
    reg_rsp.rdata   = 32'hCAFE_0001;
    @(negedge clk_i);
    chk("b2b_gnt_access", 64'(obi_rsp.gnt), 64'(0));
    chk("b2b_addr_a", 64'(reg_req.addr), 64'(32'h0300_3000));
    tick();
    reg_rsp = '0;
    @(negedge clk_i);
    chk("b2b_gnt_resp", 64'(obi_rsp.gnt), 64'(0));
    tick();
    @(negedge clk_i);
    chk("b2b_gnt1", 64'(obi_rsp.gnt), 64'(1));
    chk("b2b_gap", 64'(cyc - g1), 64'(3));
    e.rdata = 32'h0;
    e.rid   = 4'd2;
    e.err   = 1'b0;
    e.cyc   = cyc + 2;
    sb.push_back(e);
    tick();
    obi_req.req   = 1'b0;
    reg_rsp.ready = 1'b1;
    reg_rsp.rdata = 32'h7777_7777;
    @(negedge clk_i);
    chk("b2b_valid", 64'(reg_req.valid), 64'(1));
    chk("b2b_addr_b", 64'(reg_req.addr), 64'(32'h0300_3004));
    chk("b2b_wstrb_b", 64'(reg_req.wstrb), 64'(4'hC));
    tick();
    reg_rsp = '0;
    @(negedge clk_i);
    tick();
    @(negedge clk_i);
    chk("b2b_sb_empty", 64'(sb.size()), 64'(0));
    tick();

    // Reset in the middle of an access: no response may ever appear for it.
    obi_req.req     = 1'b1;
    obi_req.a.addr  = 32'h0300_4000;
    obi_req.a.we    = 1'b0;
    obi_req.a.be    = 4'hF;
    obi_req.a.aid   = 4'd6;
    @(negedge clk_i);
    chk("rstmid_gnt", 64'(obi_rsp.gnt), 64'(1));
    tick();
    obi_req.req = 1'b0;
    @(negedge clk_i);
    chk("rstmid_valid", 64'(reg_req.valid), 64'(1));
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rstmid_valid0", 64'(reg_req.valid), 64'(0));
    chk("rstmid_rvalid0", 64'(obi_rsp.rvalid), 64'(0));
    chk("rstmid_busy0", 64'(busy), 64'(0));
    tick();
    run_txn(32'h0300_4004, 1'b0, 4'hF, 32'h0, 4'd4, 2, 32'h600D_F00D, 1'b0, 1'b0);

    // A few random transactions that always finish before the timeout.
    for (int k = 0; k < 4; k++) begin
      run_txn($urandom(), 1'($urandom_range(0, 1)), 4'($urandom()), $urandom(), 4'($urandom()),
              int'($urandom_range(0, T - 1)), $urandom(), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
